// File: rtl/data_memory_responder.sv
// Word-addressed data memory with a fixed-latency request/acknowledge handshake.
// One access is in flight at a time; every output comes straight from a flop.
module data_memory_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic [15:0] DMADDR,
    input  logic        DMREQ,
    input  logic        DMWR,
    input  logic [15:0] DMDIN,
    output logic [15:0] DMDOUT,
    output logic        DMACK,
    output logic        DMBUSY,
    output logic        DMERR
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [15:0] din_q, din_d;
    logic [15:0] dout_q, dout_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic [15:0] mem [2**DEPTH_LOG2];

    logic [DEPTH_LOG2-1:0] idx;
    logic                  oor;
    logic                  do_access;
    logic [15:0]           rd_word;

    // Only the low address bits index the array; any high bit set is an error.
    assign idx       = addr_q[DEPTH_LOG2-1:0];
    assign oor       = (addr_q >> DEPTH_LOG2) != 16'd0;
    assign do_access = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign rd_word   = mem[idx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        din_d   = din_q;
        dout_d  = dout_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (DMREQ) begin
                    addr_d  = DMADDR;
                    wr_d    = DMWR;
                    din_d   = DMDIN;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    err_d   = oor;
                    if (oor) begin
                        dout_d = 16'h0000;
                    end else if (!wr_q) begin
                        dout_d = rd_word;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ack_d   = 1'b0;
                err_d   = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                ack_d   = 1'b0;
                err_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            wr_q    <= 1'b0;
            din_q   <= 16'h0000;
            dout_q  <= 16'h0000;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Array has no reset; a reset during WAIT suppresses the pending write.
    always_ff @(posedge clk) begin
        if (RST_N && do_access && wr_q && !oor) begin
            mem[idx] <= din_q;
        end
    end

    assign DMDOUT = dout_q;
    assign DMACK  = ack_q;
    assign DMBUSY = busy_q;
    assign DMERR  = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one LATENCY=2 instance for the
// main sequence and one LATENCY=1 instance for minimum-latency and held-request cases.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr, din, dout;
    logic        req, wr, ack, busy, err;
    logic [15:0] addr1, din1, dout1;
    logic        req1, wr1, ack1, busy1, err1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut (
        .clk(clk), .RST_N(rst_n), .DMADDR(addr), .DMREQ(req), .DMWR(wr),
        .DMDIN(din), .DMDOUT(dout), .DMACK(ack), .DMBUSY(busy), .DMERR(err)
    );

    data_memory_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
        .clk(clk), .RST_N(rst_n), .DMADDR(addr1), .DMREQ(req1), .DMWR(wr1),
        .DMDIN(din1), .DMDOUT(dout1), .DMACK(ack1), .DMBUSY(busy1), .DMERR(err1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one access on the LATENCY=2 instance, wait for DMACK, return the response.
    task automatic access(input string tag, input logic w, input logic [15:0] a,
                          input logic [15:0] d, output logic [15:0] rd, output logic re);
        int n;
        req  = 1'b1;
        wr   = w;
        addr = a;
        din  = d;
        tick();
        req  = 1'b0;
        n    = 0;
        while (!ack && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, 2);
        rd = dout;
        re = err;
        tick();
        check({tag, "_ackw"}, ack, 1'b0);
        check({tag, "_errlow"}, err, 1'b0);
    endtask

    logic [15:0] rd;
    logic        re;

    initial begin
        rst_n = 1'b0;
        req = 1'b0; wr = 1'b0; addr = 16'h0; din = 16'h0;
        req1 = 1'b0; wr1 = 1'b0; addr1 = 16'h0; din1 = 16'h0;
        tick();
        tick();
        check("rst_ack", ack, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_dout", dout, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Write 0x0010=BEEF, cycle by cycle
        req = 1'b1; wr = 1'b1; addr = 16'h0010; din = 16'hBEEF;
        tick();
        req = 1'b0;
        check("w_e0_busy", busy, 1'b1);
        check("w_e0_ack", ack, 1'b0);
        tick();
        check("w_e1_busy", busy, 1'b1);
        check("w_e1_ack", ack, 1'b0);
        tick();
        check("w_e2_ack", ack, 1'b1);
        check("w_e2_busy", busy, 1'b1);
        check("w_e2_err", err, 1'b0);
        tick();
        check("w_e3_ack", ack, 1'b0);
        check("w_e3_busy", busy, 1'b0);
        tick();

        access("rd10", 1'b0, 16'h0010, 16'h0, rd, re);
        check("rd10_data", rd, 16'hBEEF);
        check("rd10_err", re, 1'b0);

        // Out-of-range write must not alias onto word 0
        access("wr00", 1'b1, 16'h0000, 16'hA5A5, rd, re);
        access("wr100", 1'b1, 16'h0100, 16'hDEAD, rd, re);
        check("wr100_err", re, 1'b1);
        check("wr100_dout", rd, 16'h0000);
        access("rd00", 1'b0, 16'h0000, 16'h0, rd, re);
        check("rd00_data", rd, 16'hA5A5);
        check("rd00_err", re, 1'b0);
        access("rd100", 1'b0, 16'h0100, 16'h0, rd, re);
        check("rd100_err", re, 1'b1);
        check("rd100_dout", rd, 16'h0000);
        access("rdFFFF", 1'b0, 16'hFFFF, 16'h0, rd, re);
        check("rdFFFF_err", re, 1'b1);

        // A write keeps the previous read value on DMDOUT
        access("rd00b", 1'b0, 16'h0000, 16'h0, rd, re);
        access("wr30", 1'b1, 16'h0030, 16'h7777, rd, re);
        check("wr30_dout", rd, 16'hA5A5);
        check("wr30_err", re, 1'b0);
        access("rd30", 1'b0, 16'h0030, 16'h0, rd, re);
        check("rd30_data", rd, 16'h7777);
        access("rdFF", 1'b0, 16'h00FF, 16'h0, rd, re);
        check("rdFF_err", re, 1'b0);

        // Inputs changed after acceptance are ignored
        access("wr05", 1'b1, 16'h0005, 16'h5555, rd, re);
        access("wr06", 1'b1, 16'h0006, 16'h6666, rd, re);
        req = 1'b1; wr = 1'b0; addr = 16'h0005;
        tick();
        req = 1'b0; wr = 1'b1; addr = 16'h0006; din = 16'hFFFF;
        tick();
        tick();
        check("mid_ack", ack, 1'b1);
        check("mid_data", dout, 16'h5555);
        tick();
        wr = 1'b0;
        access("rd06", 1'b0, 16'h0006, 16'h0, rd, re);
        check("rd06_data", rd, 16'h6666);

        // Reset during WAIT aborts the write
        access("wr20", 1'b1, 16'h0020, 16'h1234, rd, re);
        req = 1'b1; wr = 1'b1; addr = 16'h0020; din = 16'h9999;
        tick();
        req = 1'b0;
        rst_n = 1'b0;
        tick();
        check("rstw_ack", ack, 1'b0);
        check("rstw_busy", busy, 1'b0);
        check("rstw_err", err, 1'b0);
        check("rstw_dout", dout, 16'h0000);
        rst_n = 1'b1;
        tick();
        check("rstw_ack2", ack, 1'b0);
        tick();
        check("rstw_ack3", ack, 1'b0);
        access("rd20", 1'b0, 16'h0020, 16'h0, rd, re);
        check("rd20_data", rd, 16'h1234);

        // LATENCY=1: request at E0 acknowledged at E1
        req1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0042; din1 = 16'hC0DE;
        tick();
        check("l1_e0_ack", ack1, 1'b0);
        check("l1_e0_busy", busy1, 1'b1);
        req1 = 1'b0;
        tick();
        check("l1_e1_ack", ack1, 1'b1);
        tick();
        check("l1_e2_ack", ack1, 1'b0);
        check("l1_e2_busy", busy1, 1'b0);

        // Held request: one single-cycle DMACK every third cycle
        req1 = 1'b1; wr1 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("held_ack_%0d", k), ack1, (k % 3 == 2) ? 1'b1 : 1'b0);
            if (k % 3 == 2) begin
                check($sformatf("held_data_%0d", k), dout1, 16'hC0DE);
            end
        end
        req1 = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 The block SHALL take parameter DEPTH_LOG2, default 8, as log2 of memory depth in 16-bit words (256 words).
REQ-002 The block SHALL take parameter LATENCY, default 2, as access wait cycles; legal range 1..15.
REQ-003 The block SHALL have one clock, clk, and reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 RST_N  input  1  synchronous active-low reset.
REQ-006 DMADDR  input  16  word address driven by the address register.
REQ-007 DMREQ  input  1  access request, level, sampled only in IDLE.
REQ-008 DMWR  input  1  1 = write, 0 = read; sampled with DMREQ.
REQ-009 DMDIN  input  16  write data; sampled with DMREQ.
REQ-010 DMDOUT  output  16  read data, valid while DMACK=1.
REQ-011 DMACK  output  1  one-cycle access-complete strobe.
REQ-012 DMBUSY  output  1  high in WAIT and RESP states.
REQ-013 DMERR  output  1  out-of-range flag, valid while DMACK=1.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, WAIT and RESP, with all outputs registered.
REQ-015 IDLE with DMREQ=1 at an edge SHALL latch DMADDR, DMWR and DMDIN, load the counter with LATENCY-1 and move to WAIT.
REQ-016 IDLE with DMREQ=0 SHALL hold IDLE.
REQ-017 WAIT with counter>0 SHALL decrement the counter; with counter=0 it SHALL perform the access and move to RESP.
REQ-018 The access SHALL write the latched data or read mem[latched address] at the WAIT->RESP edge.
REQ-019 In RESP, DMACK=1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-020 Latency SHALL be: request sampled at edge E0, DMACK high from edge E0+LATENCY to edge E0+LATENCY+1.
REQ-021 DMREQ, DMADDR, DMWR and DMDIN SHALL be ignored in WAIT and RESP; changes after E0 do not affect the access in flight.
REQ-022 A DMREQ still high at the RESP->IDLE edge SHALL NOT be accepted; it is accepted at the following edge in IDLE, giving back-to-back throughput of one access per LATENCY+2 cycles.
REQ-023 A read SHALL drive DMDOUT=mem[addr] during the DMACK cycle and hold that value until the next DMACK.
REQ-024 A write SHALL leave DMDOUT at its previous value.
REQ-025 An address is out of range when DMADDR[15:DEPTH_LOG2] != 0.
REQ-026 An out-of-range access SHALL leave memory unchanged, drive DMDOUT=16'h0000 and assert DMERR=1 with DMACK.
REQ-027 DMERR SHALL be 0 in every cycle where DMACK=0.
REQ-028 Only DMADDR[DEPTH_LOG2-1:0] SHALL index memory; there is no address wrap-around.

Reset
REQ-029 With RST_N=0 at an edge, the block SHALL set state to IDLE, counter to 0, DMACK=0, DMBUSY=0, DMERR=0 and DMDOUT=16'h0000.
REQ-030 Reset SHALL take priority over every transition.
REQ-031 Reset asserted in WAIT SHALL abort the access, write nothing and produce no DMACK.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-033 Write then read: write DMADDR=16'h0010, DMDIN=16'hBEEF, LATENCY=2, request at E0 -> DMACK at E2..E3, DMBUSY E0..E3; then read 16'h0010 -> DMDOUT=16'hBEEF, DMERR=0.
REQ-034 Out of range: read DMADDR=16'h0100 with DEPTH_LOG2=8 -> DMACK with DMERR=1 and DMDOUT=16'h0000; a prior write to 16'h0100 leaves mem[0] unchanged.
REQ-035 Input change mid-access: request a read of 16'h0005, change DMADDR to 16'h0006 at E1 -> response returns mem[5].
REQ-036 Held DMREQ: keep DMREQ=1 continuously with LATENCY=1 -> DMACK pulses every 3 cycles, each exactly 1 cycle wide.
REQ-037 Reset mid-op: write 16'h1234 to 16'h0020, pull RST_N=0 at E1 -> no DMACK, all outputs 0, and a later read of 16'h0020 returns the old value.
REQ-038 LATENCY=1: request at E0 -> DMACK high E1..E2.
